// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/mem/write-back.
// Optional macro CTRL_HALT_ON_ILLEGAL_EN: illegal opcodes halt instead of acting as NOPs.
module mips_control_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       alu_break,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch     = 4'd0,
    StFetchWait = 4'd1,
    StDecode    = 4'd2,
    StRExec     = 4'd3,
    StRWb       = 4'd4,
    StMemAddr   = 4'd5,
    StMemRd     = 4'd6,
    StMemRdWait = 4'd7,
    StLwWb      = 4'd8,
    StMemWr     = 4'd9,
    StAddiExec  = 4'd10,
    StAddiWb    = 4'd11,
    StBranch    = 4'd12,
    StJump      = 4'd13,
    StHalt      = 4'd14
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpJ     = 6'h02;

  state_e     state_q, state_d;
  logic [5:0] op_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= 6'h00;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= opcode;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_source  = 2'b00;
    halted     = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = StFetchWait;
      end
      StFetchWait: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        alu_src_b = 2'b11;
        case (opcode)
          OpRtype:     state_d = alu_break ? StHalt : StRExec;
          OpLw, OpSw:  state_d = StMemAddr;
          OpAddi:      state_d = StAddiExec;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:         state_d = StJump;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
          default:     state_d = StHalt;
`else
          default:     state_d = StFetch;
`endif
        endcase
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Bit 3 separates sw (2b) from lw (23).
        state_d   = op_q[3] ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = StMemRdWait;
      end
      StMemRdWait: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = StLwWb;
      end
      StLwWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_source = 2'b01;
        // Mealy: bit 0 of the latched opcode selects bne over beq.
        pc_write  = op_q[0] ? !zero : zero;
      end
      StJump: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: state sequences and key control outputs per instruction.
module tb_mips_control_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       alu_break;
  logic       zero;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, halted;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // Per-cycle observation record for one instruction.
  int         ob_st[16];
  logic       ob_pcw[16], ob_iod[16], ob_mr[16], ob_mw[16], ob_irw[16];
  logic       ob_rd[16], ob_m2r[16], ob_rw[16], ob_asa[16], ob_hlt[16];
  logic [1:0] ob_asb[16], ob_psrc[16];
  logic [2:0] ob_aop[16];
  int         exp_q[$];

  mips_control_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .alu_break  (alu_break),
    .zero       (zero),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .halted     (halted),
    .state      (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs n observed cycles starting in FETCH; optionally scrambles opcode after DECODE.
  task automatic run(input logic [5:0] op, input logic brk, input logic z, input int n,
                     input bit scramble);
    opcode    = op;
    alu_break = brk;
    zero      = z;
    for (int i = 0; i < n; i++) begin
      ob_st[i]   = int'(state);
      ob_pcw[i]  = pc_write;
      ob_iod[i]  = i_or_d;
      ob_mr[i]   = mem_read;
      ob_mw[i]   = mem_write;
      ob_irw[i]  = ir_write;
      ob_rd[i]   = reg_dst;
      ob_m2r[i]  = mem_to_reg;
      ob_rw[i]   = reg_write;
      ob_asa[i]  = alu_src_a;
      ob_hlt[i]  = halted;
      ob_asb[i]  = alu_src_b;
      ob_psrc[i] = pc_source;
      ob_aop[i]  = alu_op;
      if (i < n - 1) begin
        step();
        if (scramble && ob_st[i] == 2) opcode = 6'h3f;
      end
    end
  endtask

  task automatic check_seq(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_state%0d", tag, i), ob_st[i], exp_q[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
  endtask

  int rw_cnt;
  int not_halt;

  initial begin
    reset     = 1'b1;
    opcode    = 6'h00;
    alu_break = 1'b0;
    zero      = 1'b0;
    step();
    check("rst_state", state, 0);
    check("rst_mem_read", mem_read, 1);
    check("rst_alu_src_b", alu_src_b, 2'b01);
    check("rst_enables", {pc_write, ir_write, reg_write, mem_write, halted}, 0);
    #2;
    reset = 1'b0;
    #1;
    check("rel_state", state, 0);

    // R-type add
    run(6'h00, 1'b0, 1'b0, 6, 1'b0);
    exp_q = '{0, 1, 2, 3, 4, 0};
    check_seq("r");
    check("r_fw_ir_write", ob_irw[1], 1);
    check("r_fw_pc_write", ob_pcw[1], 1);
    check("r_exec_alu_op", ob_aop[3], 3'b010);
    check("r_exec_src_a", ob_asa[3], 1);
    check("r_wb_reg_write", ob_rw[4], 1);
    check("r_wb_reg_dst", ob_rd[4], 1);
    rw_cnt = 0;
    for (int i = 0; i < 5; i++) rw_cnt += int'(ob_rw[i]) + int'(ob_rd[i]);
    check("r_reg_write_once", rw_cnt, 2);

    // lw
    run(6'h23, 1'b0, 1'b0, 8, 1'b0);
    exp_q = '{0, 1, 2, 5, 6, 7, 8, 0};
    check_seq("lw");
    check("lw_addr_src_b", ob_asb[3], 2'b10);
    check("lw_i_or_d", {ob_iod[3], ob_iod[4], ob_iod[5], ob_iod[6]}, 4'b0110);
    check("lw_mem_read", {ob_mr[4], ob_mr[5]}, 2'b11);
    check("lw_wb", {ob_m2r[6], ob_rw[6]}, 2'b11);

    // sw
    run(6'h2b, 1'b0, 1'b0, 6, 1'b0);
    exp_q = '{0, 1, 2, 5, 9, 0};
    check_seq("sw");
    check("sw_mem_write", {ob_mw[4], ob_iod[4], ob_rw[4]}, 3'b110);

    // addi
    run(6'h08, 1'b0, 1'b0, 6, 1'b0);
    exp_q = '{0, 1, 2, 10, 11, 0};
    check_seq("addi");
    check("addi_exec", {ob_asa[3], ob_asb[3], ob_aop[3]}, {1'b1, 2'b10, 3'b000});
    check("addi_wb", {ob_rw[4], ob_rd[4]}, 2'b10);

    // beq taken, opcode scrambled after DECODE must not matter
    run(6'h04, 1'b0, 1'b1, 5, 1'b1);
    exp_q = '{0, 1, 2, 12, 0};
    check_seq("beq");
    check("decode_src_b", ob_asb[2], 2'b11);
    check("beq_t_pc_write", ob_pcw[3], 1);
    check("beq_t_pc_source", ob_psrc[3], 2'b01);
    check("beq_alu_op", ob_aop[3], 3'b001);
    run(6'h04, 1'b0, 1'b0, 5, 1'b0);
    check("beq_nt_pc_write", ob_pcw[3], 0);
    run(6'h05, 1'b0, 1'b1, 5, 1'b0);
    check("bne_z1_pc_write", ob_pcw[3], 0);
    run(6'h05, 1'b0, 1'b0, 5, 1'b0);
    check("bne_z0_pc_write", ob_pcw[3], 1);

    // Mealy branch: pc_write follows zero within the BRANCH cycle
    run(6'h04, 1'b0, 1'b0, 4, 1'b0);
    check("mealy_state", state, 12);
    zero = 1'b1;
    #1;
    check("mealy_pc_write", pc_write, 1);
    step();
    check("mealy_back", state, 0);

    // jump
    run(6'h02, 1'b0, 1'b0, 5, 1'b0);
    exp_q = '{0, 1, 2, 13, 0};
    check_seq("j");
    check("j_out", {ob_pcw[3], ob_psrc[3]}, {1'b1, 2'b10});

    // illegal opcode
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    run(6'h3f, 1'b0, 1'b0, 4, 1'b0);
    exp_q = '{0, 1, 2, 14};
    check_seq("ill");
    check("ill_halted", ob_hlt[3], 1);
    do_reset();
    check("ill_reset", state, 0);
`else
    run(6'h3f, 1'b0, 1'b0, 4, 1'b0);
    exp_q = '{0, 1, 2, 0};
    check_seq("ill");
    check("ill_no_writes", {ob_pcw[2], ob_rw[2], ob_mw[2], ob_irw[2], ob_hlt[2]}, 0);
`endif

    // break -> HALT, held for 20 cycles
    run(6'h00, 1'b1, 1'b0, 4, 1'b0);
    exp_q = '{0, 1, 2, 14};
    check_seq("brk");
    check("brk_halted", ob_hlt[3], 1);
    alu_break = 1'b0;
    not_halt  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (state != 4'd14 || !halted || pc_write || reg_write || mem_write || ir_write)
        not_halt++;
    end
    check("halt_hold", not_halt, 0);
    do_reset();
    check("halt_reset_state", state, 0);
    check("halt_reset_halted", halted, 0);

    // reset during MEM_WR drops mem_write asynchronously
    run(6'h2b, 1'b0, 1'b0, 5, 1'b0);
    check("mw_pre_state", state, 9);
    check("mw_pre_write", mem_write, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mw_rst_write", mem_write, 0);
    check("mw_rst_state", state, 0);
    check("mw_rst_mem_read", mem_read, 1);
    #2;
    reset = 1'b0;
    step();
    check("mw_after_rel", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
